// File: rtl/grabador_loop.sv
// Tick-paced sample recorder/looper: records nota into an internal RAM
// on each sample tick, then plays it back one-shot or looped.
// Ports:
//   clk100mhz, rst (sync, active-high)
//   rec, play, loop_en    level controls
//   nota                  sample to record
//   salida                registered playback sample
//   addr, length          current address, recorded sample count
//   state                 IDLE=00 REC=01 PLAY=10 DONE=11
//   full                  last recording hit end of memory
//   tick                  one-cycle sample strobe
module grabador_loop #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 9,
  parameter int TICK_DIV = 2_000_000
) (
  input  logic              clk100mhz,
  input  logic              rst,
  input  logic              rec,
  input  logic              play,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] nota,
  output logic [DATA_W-1:0] salida,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   length,
  output logic [1:0]        state,
  output logic              full,
  output logic              tick
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10,
    S_DONE = 2'b11
  } st_e;

  st_e               st_q, st_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rec_q, play_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] sal_q, sal_d;
  logic              we;
  logic              rec_rise, play_rise;
  logic              play_last;

  logic [DATA_W-1:0] mem [DEPTH];

  assign tick      = (cnt_q == CNT_MAX);
  assign rec_rise  = rec & ~rec_q;
  assign play_rise = play & ~play_q;
  assign play_last = ({1'b0, addr_q} == (len_q - LEN_ONE));

  // Free-running divider; tick only ever acts as a clock enable.
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      cnt_q  <= '0;
      rec_q  <= 1'b0;
      play_q <= 1'b0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;
      rec_q  <= rec;
      play_q <= play;
    end
  end

  // Sample RAM survives reset.
  always_ff @(posedge clk100mhz) begin
    if (we) mem[addr_q] <= nota;
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      st_q   <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      full_q <= 1'b0;
      sal_q  <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      len_q  <= len_d;
      full_q <= full_d;
      sal_q  <= sal_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    len_d  = len_q;
    full_d = full_q;
    sal_d  = sal_q;
    we     = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (rec_rise) begin
          st_d   = S_REC;
          addr_d = '0;
          len_d  = '0;
          full_d = 1'b0;
        end else if (play_rise && len_q != '0) begin
          st_d   = S_PLAY;
          addr_d = '0;
        end
      end
      S_REC: begin
        // A tick that coincides with rec falling still stores its sample.
        if (tick) begin
          we    = 1'b1;
          len_d = {1'b0, addr_q} + LEN_ONE;
          if (addr_q == '1) begin
            full_d = 1'b1;
            st_d   = S_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        if (!rec) st_d = S_IDLE;
      end
      S_PLAY: begin
        if (!play) begin
          st_d   = S_IDLE;
          sal_d  = '0;
          addr_d = '0;
        end else if (tick) begin
          sal_d = mem[addr_q];
          if (play_last) begin
            if (loop_en) addr_d = '0;
            else         st_d   = S_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!play) begin
          st_d   = S_IDLE;
          sal_d  = '0;
          addr_d = '0;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign salida = sal_q;
  assign addr   = addr_q;
  assign length = len_q;
  assign state  = st_q;
  assign full   = full_q;

endmodule

// File: tb/tb_grabador_loop.sv
// Randomized bench for grabador_loop (DATA_W=8, ADDR_W=3, TICK_DIV=4)
// against a sample-list model of record/playback.
module tb_grabador_loop;

  logic       clk = 1'b0;
  logic       rst, rec, play, loop_en;
  logic [7:0] nota, salida;
  logic [2:0] addr;
  logic [3:0] length;
  logic [1:0] state;
  logic       full, tick;

  grabador_loop #(.DATA_W(8), .ADDR_W(3), .TICK_DIV(4)) dut (
    .clk100mhz(clk), .rst(rst), .rec(rec), .play(play),
    .loop_en(loop_en), .nota(nota), .salida(salida), .addr(addr),
    .length(length), .state(state), .full(full), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model: recorded samples and status
  logic [7:0] mem_m [8];
  int         len_m = 0;
  bit         full_m = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (tick !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    n_chk++;
    if (tick !== 1'b1) $display("FAIL tick_timeout got %b exp 1", tick);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1; rec = 0; play = 0; loop_en = 0; nota = 0;
    step();
    step();
    rst = 0;
    len_m = 0; full_m = 0;
    n_chk++;
    if ({state, addr, length, salida, full} !== '0)
      $display("FAIL reset_outs got st=%0d a=%0d l=%0d s=%h f=%b exp 0",
               state, addr, length, salida, full);
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (tick !== ((k % 4) == 3))
        $display("FAIL tick_cycle%0d got %b exp %b", k, tick, (k % 4) == 3);
      else n_pass++;
      step();
    end
  endtask

  task automatic do_record(int n, bit drop, bit fixed);
    logic [1:0] est;
    rec = 0;
    step();
    rec = 1;
    step();
    len_m = 0; full_m = 0;
    n_chk++;
    if (state !== 2'b01 || length !== 0 || full !== 0)
      $display("FAIL rec_entry got st=%0d l=%0d f=%b exp 1 0 0",
               state, length, full);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      nota = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      wait_tick();
      if (drop && i == n - 1) rec = 0;
      step();
      if (!full_m) begin
        mem_m[len_m] = nota;
        len_m++;
        if (len_m == 8) full_m = 1;
      end
      est = (full_m || (drop && i == n - 1)) ? 2'b00 : 2'b01;
      n_chk++;
      if (state !== est)
        $display("FAIL rec_state_w%0d got %0d exp %0d", i, state, est);
      else n_pass++;
    end
    rec = 0;
    step();
    n_chk++;
    if (state !== 2'b00 || length !== 4'(len_m) || full !== full_m)
      $display("FAIL rec_end got st=%0d l=%0d f=%b exp 0 %0d %b",
               state, length, full, len_m, full_m);
    else n_pass++;
  endtask

  task automatic do_play(int nt, bit lp, bit drop);
    int p = 0;
    bit done = 0;
    logic [7:0] es = 0;
    logic [1:0] est;
    play = 0;
    step();
    loop_en = lp;
    play = 1;
    step();
    if (len_m == 0) begin
      n_chk++;
      if (state !== 2'b00 || salida !== 0 || length !== 0)
        $display("FAIL play_empty got st=%0d s=%h l=%0d exp 0 0 0",
                 state, salida, length);
      else n_pass++;
      play = 0;
      step();
      return;
    end
    n_chk++;
    if (state !== 2'b10 || addr !== 0)
      $display("FAIL play_entry got st=%0d a=%0d exp 2 0", state, addr);
    else n_pass++;
    for (int j = 0; j < nt; j++) begin
      rec = 1'($urandom);
      wait_tick();
      if (drop && j == nt - 1) begin
        play = 0;
        rec = 0;
        step();
        n_chk++;
        if (state !== 2'b00 || salida !== 0 || addr !== 0)
          $display("FAIL play_drop_tick got st=%0d s=%h a=%0d exp 0 0 0",
                   state, salida, addr);
        else n_pass++;
        return;
      end
      step();
      if (!done) begin
        es = mem_m[p];
        if (p == len_m - 1) begin
          if (lp) p = 0;
          else done = 1;
        end else p++;
      end
      est = done ? 2'b11 : 2'b10;
      n_chk++;
      if (salida !== es || state !== est || addr !== 3'(p))
        $display("FAIL play_t%0d got s=%h st=%0d a=%0d exp %h %0d %0d",
                 j, salida, state, addr, es, est, p);
      else n_pass++;
    end
    play = 0;
    rec = 0;
    step();
    n_chk++;
    if (state !== 2'b00 || salida !== 0 || addr !== 0 ||
        length !== 4'(len_m))
      $display("FAIL play_stop got st=%0d s=%h a=%0d l=%0d exp 0 0 0 %0d",
               state, salida, addr, length, len_m);
    else n_pass++;
  endtask

  task automatic test_empty_play();
    do_play(3, 0, 0);
  endtask

  task automatic test_spec_seq();
    do_record(3, 0, 1);
    do_play(5, 0, 0);
    do_play(5, 1, 0);
  endtask

  task automatic test_full();
    do_record(10, 0, 0);
    do_play(10, 1, 0);
    do_record(2, 1, 0);
    do_play(3, 0, 0);
  endtask

  task automatic test_priority();
    rec = 0; play = 0;
    step();
    rec = 1; play = 1;
    step();
    n_chk++;
    if (state !== 2'b01)
      $display("FAIL rec_over_play got %0d exp 1", state);
    else n_pass++;
    rst = 1; rec = 0; play = 0;
    step();
    rst = 0;
    len_m = 0; full_m = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      do_record($urandom_range(1, 10), 1'($urandom), 0);
      do_play($urandom_range(1, 12), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_play();
    do_record(4, 0, 0);
    play = 0;
    step();
    loop_en = 1;
    play = 1;
    step();
    wait_tick();
    step();
    wait_tick();
    step();
    rst = 1;
    step();
    n_chk++;
    if ({state, addr, length, salida, full} !== '0)
      $display("FAIL rst_mid_play got st=%0d a=%0d l=%0d s=%h f=%b exp 0",
               state, addr, length, salida, full);
    else n_pass++;
    rst = 0; play = 0;
    len_m = 0; full_m = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_empty_play();
    test_spec_seq();
    test_full();
    test_priority();
    test_random();
    test_reset_mid_play();
    test_empty_play();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
